// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-programmable serial pattern detector with
// Mealy/Moore output, overlap control and a saturating match counter.
module seq_detector_param #(
    parameter int              CNT_W   = 8,
    parameter int              PAT_W   = 4,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_W'('b1101)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             x_i,
    input  logic             x_valid_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic             pat_load_i,
    input  logic             moore_mode_i,
    input  logic             overlap_i,
    output logic             z_o,
    output logic [PAT_W-1:0] seq_o,
    output logic [CNT_W-1:0] match_cnt_o,
    output logic             cnt_sat_o
);
    localparam int FW = $clog2(PAT_W);

    logic [PAT_W-1:0] pat_q, pat_d, seq_q, seq_d, shifted;
    logic [FW-1:0]    fill_q, fill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             z_q, z_d, full, hit;

    assign shifted     = {seq_q[PAT_W-2:0], x_i};
    assign full        = fill_q == FW'(PAT_W - 1);
    assign hit         = x_valid_i & ~pat_load_i & full & (shifted == pat_q);
    assign z_o         = moore_mode_i ? z_q : hit;
    assign seq_o       = seq_q;
    assign match_cnt_o = cnt_q;
    assign cnt_sat_o   = &cnt_q;

    // fill only counts bits belonging to the current detection window;
    // seq keeps shifting across a non-overlap match so the display stays live
    always_comb begin
        pat_d  = pat_load_i ? pattern_i : pat_q;
        seq_d  = pat_load_i ? '0 : x_valid_i ? shifted : seq_q;
        fill_d = pat_load_i ? '0 :
                 !x_valid_i ? fill_q :
                 (hit && !overlap_i) ? '0 :
                 full ? fill_q : fill_q + FW'(1);
        cnt_d  = pat_load_i ? '0 : (hit && !cnt_sat_o) ? cnt_q + CNT_W'(1) : cnt_q;
        z_d    = hit;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pat_q  <= PAT_RST;
            seq_q  <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            z_q    <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            seq_q  <= seq_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            z_q    <= z_d;
        end
    end
endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised successor to the fixed 4-bit Mealy "1101" detector.
- Detects a runtime-programmable PAT_W-bit pattern on a serial bit stream qualified by a valid strobe.
- Selectable Mealy or Moore output timing and overlapping or non-overlapping detection, plus a saturating match counter.
- Sits on the serial-input path of the lab datapath; z drives downstream logic and seq/match_cnt feed the board display.

Parameters:
- PAT_W, 4, pattern length in bits (min 2, max 16).
- CNT_W, 8, match counter width.
- PAT_RST, 4'b1101 (PAT_W bits), pattern register value after reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- x  input  1  serial data bit.
- x_valid  input  1  x is accepted on this edge when high.
- pattern  input  PAT_W  new pattern, captured when pat_load=1; MSB is the oldest bit.
- pat_load  input  1  load pattern and clear detection history.
- moore_mode  input  1  0: Mealy output, 1: Moore (registered) output.
- overlap  input  1  1: overlapping matches allowed; 0: history cleared after each match.
- z  output  1  match indication.
- seq  output  PAT_W  last PAT_W accepted bits, newest at LSB.
- match_cnt  output  CNT_W  number of matches since reset/pat_load.
- cnt_sat  output  1  high while match_cnt is at all-ones.

Behaviour:
- Reset (sync, active-high, highest priority):
  - pat_q=PAT_RST, seq=0, fill=0, match_cnt=0, z_q=0.
  - z=0 in the cycle after reset regardless of x.
- fill: internal counter 0..PAT_W-1, saturating at PAT_W-1. It counts accepted bits since reset, pat_load, or a non-overlap match.
- hit (combinational): x_valid & !pat_load & (fill==PAT_W-1) & ({seq[PAT_W-2:0],x}==pat_q).
- Accept (x_valid=1, no pat_load): seq <= {seq[PAT_W-2:0],x}.
  - fill increments, saturating at PAT_W-1.
  - If hit & !overlap: fill <= 0. seq still shifts.
- pat_load=1: pat_q<=pattern, seq<=0, fill<=0, match_cnt<=0, z_q<=0.
  - A simultaneous x_valid bit is discarded; no hit is possible that cycle.
- x_valid=0: seq, fill and counter hold; z (Mealy) is 0.
- Mealy (moore_mode=0): z = hit, combinational, in the same cycle the completing bit is presented.
- Moore (moore_mode=1): z = z_q, where z_q <= hit every edge.
  - z goes high for exactly one cycle, one cycle after the completing bit.
- z_q updates in both modes. Mode and overlap are quasi-static; a change takes effect on the next edge and preserves history.
- match_cnt increments on every hit and saturates at 2^CNT_W-1 (no wrap). cnt_sat = &match_cnt.
- Reset asserted mid-pattern: partial history is lost; a pattern straddling reset is never detected.

Test Plan:
- Reset, pattern 1101, overlap=1, Mealy. Stream 1,1,0,1,1,0,1 (one bit per cycle) -> z=1 combinationally on bits 4 and 7; match_cnt=2; seq=4'b1101 after bit 7.
- Same stream with overlap=0 -> z=1 only on bit 4; match_cnt=1; seq still 4'b1101 at end.
- Same stream, overlap=1, Moore -> z high for exactly one cycle each, in the cycles after bits 4 and 7; z=0 during bits 4 and 7.
- Stream 1,1,0,1 with x_valid=0 gaps between bits -> match only on the final valid bit; seq, fill and z hold during the gaps.
- pat_load with pattern=4'b0110 in the same cycle as x_valid=1:
  - Required: history and count cleared, that bit discarded.
  - Then stream 0,1,1,0 -> one match, match_cnt=1.
- CNT_W=2, alternating stream 1101 repeated with overlap=0 -> match_cnt counts 1,2,3,3; cnt_sat=1 from the third match. Reset asserted mid-pattern clears all state and outputs are 0 on the next cycle.
